// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned dmem_latency_max_gp = 15;
    localparam int unsigned dmem_cnt_width_gp   = 4;
    localparam int unsigned dmem_data_width_gp  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_resp_state_e;

    typedef struct packed {
        logic [dmem_data_width_gp-1:0] write_data;
        logic                          valid;
        logic                          wen;
        logic                          byte_not_word;
        logic                          yumi;
    } mem_in_s;

    typedef struct packed {
        logic [dmem_data_width_gp-1:0] read_data;
        logic                          valid;
        logic                          yumi;
    } mem_out_s;

    // One-hot byte-write enable for a lane.
    function automatic logic [3:0] lane_byte_en(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side load/store port bundle between the core and the data memory.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    mem_in_s     to_mem_i;
    logic [31:0] data_mem_addr_i;
    mem_out_s    from_mem_o;
    logic        error_o;

    modport master (
        output to_mem_i,
        output data_mem_addr_i,
        input  from_mem_o,
        input  error_o
    );

    modport slave (
        input  to_mem_i,
        input  data_mem_addr_i,
        output from_mem_o,
        output error_o
    );

endinterface

// File: rtl/dmem_bank.sv
// Single-port synchronous word RAM with per-byte write enables and registered read.
module dmem_bank #(
    parameter int unsigned addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    en,
    input  logic [3:0]              be,
    input  logic [addr_width_p-1:0] addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             q
);

    localparam int unsigned depth_lp = 1 << addr_width_p;

    logic [31:0] mem [depth_lp];

    // Array contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register only updates on loads, so it holds through the response.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            q <= '0;
        end else if (en && (be == 4'b0000)) begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits latency_p cycles,
// then holds the response until the core takes it.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned cnt_width_lp = dmem_cnt_width_gp;

    dmem_resp_state_e          state;
    logic [cnt_width_lp-1:0]   cnt;
    mem_in_s                   req;
    logic                      accept_c;
    logic [1:0]                lane;
    logic [addr_width_p-1:0]   word_idx;
    logic [3:0]                be_c;
    logic [31:0]               wdata_c;
    logic [31:0]               q;
    logic [31:0]               lane_data_c;
    logic [31:0]               read_data_c;
    logic [1:0]                lane_r;
    logic                      store_r;
    logic                      byte_r;
    logic                      valid_r;
    logic                      error_r;
    logic                      unused_addr_bits;

    assign req              = bus.to_mem_i;
    assign word_idx         = bus.data_mem_addr_i[addr_width_p+1:2];
    assign lane             = bus.data_mem_addr_i[1:0];
    assign unused_addr_bits = ^bus.data_mem_addr_i[31:addr_width_p+2];

    // Requests are only seen in IDLE; a valid held through WAIT/RESP is ignored.
    assign accept_c = (state == IDLE) && req.valid;

    always_comb begin
        be_c    = 4'b0000;
        wdata_c = req.write_data;
        if (req.wen) begin
            if (req.byte_not_word) begin
                be_c    = lane_byte_en(lane);
                wdata_c = {4{req.write_data[7:0]}};
            end else begin
                be_c = 4'b1111;
            end
        end
    end

    dmem_bank #(
        .addr_width_p (addr_width_p)
    ) u_bank (
        .clk     (clk),
        .n_reset (n_reset),
        .en      (accept_c),
        .be      (be_c),
        .addr    (word_idx),
        .wdata   (wdata_c),
        .q       (q)
    );

    // Lane select and zero-extension on the registered read word.
    always_comb begin
        lane_data_c = q;
        if (byte_r) begin
            lane_data_c = {24'b0, q[{lane_r, 3'b000} +: 8]};
        end
        read_data_c = store_r ? 32'b0 : lane_data_c;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            lane_r  <= 2'b00;
            store_r <= 1'b0;
            byte_r  <= 1'b0;
            valid_r <= 1'b0;
            error_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        lane_r  <= lane;
                        store_r <= req.wen;
                        byte_r  <= req.byte_not_word;
                        // Misaligned word access still goes to the aligned word.
                        if (!req.byte_not_word && (lane != 2'b00)) begin
                            error_r <= 1'b1;
                        end
                        if (latency_p == 0) begin
                            state   <= RESP;
                            valid_r <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= cnt_width_lp'(latency_p);
                        end
                    end
                end
                WAIT: begin
                    if (cnt <= cnt_width_lp'(1)) begin
                        state   <= RESP;
                        valid_r <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt - cnt_width_lp'(1);
                    end
                end
                RESP: begin
                    if (req.yumi) begin
                        state   <= IDLE;
                        valid_r <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.from_mem_o = '{read_data: read_data_c, valid: valid_r, yumi: accept_c};
    assign bus.error_o    = error_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expected responses, monitor checks them.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    logic n_reset;

    always #5 clk = ~clk;

    dmem_responder_if bus();

    dmem_responder #(
        .addr_width_p (10),
        .latency_p    (LAT)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int          n_checks    = 0;
    int          n_pass      = 0;
    int          yumi_pulses = 0;
    int          n_accepts   = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Response monitor: pops an expectation at every response handshake.
    always @(negedge clk) begin
        if (bus.from_mem_o.yumi) yumi_pulses++;
        if (n_reset && bus.from_mem_o.valid && bus.to_mem_i.yumi) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got %08h expected no response", bus.from_mem_o.read_data);
            end else begin
                chk("resp_data", bus.from_mem_o.read_data, exp_q.pop_front());
            end
        end
    end

    task automatic xact(input string name, input logic [31:0] addr, input logic wen,
                        input logic bnw, input logic [31:0] wd, input logic [31:0] exp,
                        input int yumi_delay, input bit hold_valid);
        int          n;
        int          lat;
        logic [31:0] rd0;
        @(posedge clk); #1;
        bus.data_mem_addr_i        = addr;
        bus.to_mem_i.wen           = wen;
        bus.to_mem_i.byte_not_word = bnw;
        bus.to_mem_i.write_data    = wd;
        bus.to_mem_i.valid         = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.from_mem_o.yumi && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.from_mem_o.yumi) begin
            n_checks++;
            $display("FAIL %s_accept: got no yumi expected yumi within 20 cycles", name);
            bus.to_mem_i.valid = 1'b0;
            return;
        end
        n_accepts++;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        if (!hold_valid) bus.to_mem_i.valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.from_mem_o.valid && lat < 40);
        chk({name, "_latency"}, 32'(lat), 32'(LAT + 1));
        rd0 = bus.from_mem_o.read_data;
        for (int i = 0; i < yumi_delay; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({name, "_hold_valid"}, 32'(bus.from_mem_o.valid), 32'd1);
            chk({name, "_hold_data"}, bus.from_mem_o.read_data, rd0);
        end
        @(posedge clk); #1;
        bus.to_mem_i.yumi = 1'b1;
        @(posedge clk); #1;
        bus.to_mem_i.yumi  = 1'b0;
        bus.to_mem_i.valid = 1'b0;
        @(negedge clk);
        chk({name, "_valid_drop"}, 32'(bus.from_mem_o.valid), 32'd0);
    endtask

    // Accept a request, then pull reset while it sits in WAIT.
    task automatic reset_in_wait(input string name, input logic [31:0] addr, input logic wen,
                                 input logic [31:0] wd);
        int n;
        @(posedge clk); #1;
        bus.data_mem_addr_i        = addr;
        bus.to_mem_i.wen           = wen;
        bus.to_mem_i.byte_not_word = 1'b0;
        bus.to_mem_i.write_data    = wd;
        bus.to_mem_i.valid         = 1'b1;
        @(negedge clk);
        n = 0;
        while (!bus.from_mem_o.yumi && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.from_mem_o.yumi) begin
            n_checks++;
            $display("FAIL %s_accept: got no yumi expected yumi within 20 cycles", name);
        end else begin
            n_accepts++;
        end
        @(posedge clk); #1;
        bus.to_mem_i.valid = 1'b0;
        @(negedge clk);
        n_reset = 1'b0;
        #1;
        chk({name, "_valid"}, 32'(bus.from_mem_o.valid), 32'd0);
        chk({name, "_yumi"}, 32'(bus.from_mem_o.yumi), 32'd0);
        chk({name, "_rdata"}, bus.from_mem_o.read_data, 32'd0);
        chk({name, "_error"}, 32'(bus.error_o), 32'd0);
        @(posedge clk); #1;
        n_reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_reset             = 1'b1;
        bus.to_mem_i        = '0;
        bus.data_mem_addr_i = 32'd0;
        #1 n_reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.from_mem_o.valid), 32'd0);
        chk("rst_yumi", 32'(bus.from_mem_o.yumi), 32'd0);
        chk("rst_rdata", bus.from_mem_o.read_data, 32'd0);
        chk("rst_error", 32'(bus.error_o), 32'd0);
        @(posedge clk); #1;
        n_reset = 1'b1;

        xact("st_word",   32'h0000_0010, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 0, 1'b0);
        xact("ld_word",   32'h0000_0010, 1'b0, 1'b0, 32'h0,         32'hDEAD_BEEF, 0, 1'b0);
        xact("st_word2",  32'h0000_0010, 1'b1, 1'b0, 32'h1122_3344, 32'h0000_0000, 1, 1'b0);
        xact("st_byte",   32'h0000_0013, 1'b1, 1'b1, 32'h5555_55AA, 32'h0000_0000, 0, 1'b0);
        xact("ld_merged", 32'h0000_0010, 1'b0, 1'b0, 32'h0,         32'hAA22_3344, 5, 1'b0);
        xact("ld_byte3",  32'h0000_0013, 1'b0, 1'b1, 32'h0,         32'h0000_00AA, 0, 1'b1);
        xact("ld_byte1",  32'h0000_0011, 1'b0, 1'b1, 32'h0,         32'h0000_0033, 2, 1'b1);
        xact("ld_wrap",   32'h0000_4010, 1'b0, 1'b0, 32'h0,         32'hAA22_3344, 0, 1'b0);
        chk("error_clean", 32'(bus.error_o), 32'd0);

        xact("st_w0",     32'h0000_0000, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h0000_0000, 0, 1'b0);
        xact("ld_misal",  32'h0000_1002, 1'b0, 1'b0, 32'h0,         32'hCAFE_F00D, 0, 1'b0);
        chk("error_set", 32'(bus.error_o), 32'd1);
        xact("ld_after",  32'h0000_0010, 1'b0, 1'b0, 32'h0,         32'hAA22_3344, 0, 1'b0);
        chk("error_sticky", 32'(bus.error_o), 32'd1);

        reset_in_wait("rst_st", 32'h0000_0020, 1'b1, 32'h1234_5678);
        xact("ld_rst_st", 32'h0000_0020, 1'b0, 1'b0, 32'h0,         32'h1234_5678, 0, 1'b0);
        reset_in_wait("rst_ld", 32'h0000_0010, 1'b0, 32'h0);
        xact("ld_rst_ld", 32'h0000_0010, 1'b0, 1'b0, 32'h0,         32'hAA22_3344, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("yumi_pulses", 32'(yumi_pulses), 32'(n_accepts));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
